// File: rtl/pll_phase_ctrl.sv
// PLL reset/lock sequencer with a handshaked dynamic phase-shift pulse generator.
// Optional macro PLL_PHASE_CTRL_RELOCK_EN: a lock drop aborts any command and restarts the reset sequence.
module pll_phase_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned PULSE_W      = 4,
    parameter int unsigned GAP_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [2:0] ps_sel,
    output logic       ps_dir,
    output logic       ps_pulse,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_sel,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_steps,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic       locked,
    output logic       err_timeout,
    output logic       lock_lost
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [2:0] {
        ST_RST, ST_WLOCK, ST_IDLE, ST_SETUP, ST_PHI, ST_PLO
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [STEP_W-1:0]  steps, steps_nxt;
    logic               lock_meta, lock_sync;
    logic               hs, operational, lock_drop;
    logic               done_nxt, err_nxt, tmo_set, load_ps;

    assign hs          = cmd_valid & cmd_ready;
    assign operational = (state == ST_IDLE) || (state == ST_SETUP) ||
                         (state == ST_PHI)  || (state == ST_PLO);
    assign lock_drop   = operational & ~lock_sync;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
            cnt   <= '0;
            steps <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            steps <= steps_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        steps_nxt = steps;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        tmo_set   = 1'b0;
        load_ps   = 1'b0;
        case (state)
            ST_RST: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_nxt = ST_WLOCK;
                    cnt_nxt   = '0;
                end
            end
            ST_WLOCK: begin
                if (lock_sync) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    tmo_set   = 1'b1;
                    state_nxt = ST_RST;
                    cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                cnt_nxt = '0;
                if (hs) begin
                    steps_nxt = cmd_steps;
                    if (cmd_sel == SEL_W'(7)) begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                    end else begin
                        load_ps = 1'b1;
                        if (cmd_steps == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_SETUP;
                        end
                    end
                end
            end
            ST_SETUP: begin
                state_nxt = ST_PHI;
                cnt_nxt   = '0;
            end
            ST_PHI: begin
                if (cnt == CNT_W'(PULSE_W - 1)) begin
                    state_nxt = ST_PLO;
                    cnt_nxt   = '0;
                end
            end
            ST_PLO: begin
                // Step count is at least 1 here, so the decrement never wraps
                if (cnt == CNT_W'(GAP_W - 1)) begin
                    cnt_nxt   = '0;
                    steps_nxt = steps - 1'b1;
                    if (steps == STEP_W'(1)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_PHI;
                    end
                end
            end
            default: begin
                state_nxt = ST_RST;
                cnt_nxt   = '0;
            end
        endcase
`ifdef PLL_PHASE_CTRL_RELOCK_EN
        if (lock_drop) begin
            state_nxt = ST_RST;
            cnt_nxt   = '0;
            load_ps   = 1'b0;
            done_nxt  = (state != ST_IDLE);
            err_nxt   = (state != ST_IDLE);
        end
`endif
    end

    // Outputs decoded from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_reset   <= 1'b1;
            ps_sel      <= '0;
            ps_dir      <= 1'b0;
            ps_pulse    <= 1'b0;
            cmd_ready   <= 1'b0;
            cmd_done    <= 1'b0;
            cmd_err     <= 1'b0;
            locked      <= 1'b0;
            err_timeout <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            pll_reset <= (state_nxt == ST_RST);
            ps_pulse  <= (state_nxt == ST_PHI);
            locked    <= (state_nxt == ST_IDLE) || (state_nxt == ST_SETUP) ||
                         (state_nxt == ST_PHI)  || (state_nxt == ST_PLO);
            // lock_meta is what lock_sync becomes at this edge, keeping ready aligned with lock
            cmd_ready <= (state_nxt == ST_IDLE) && lock_meta && !hs;
            cmd_done  <= done_nxt;
            cmd_err   <= err_nxt;
            if (load_ps) begin
                ps_sel <= cmd_sel;
                ps_dir <= cmd_dir;
            end
            if (tmo_set) err_timeout <= 1'b1;
            if (lock_drop) lock_lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Randomized self-checking bench for pll_phase_ctrl; expected waveforms come from arithmetic on the command.
module tb_pll_phase_ctrl;

    localparam int PW = 4;
    localparam int GW = 4;
`ifdef PLL_PHASE_CTRL_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_sel = '0;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_steps = '0;
    logic       pll_reset, ps_dir, ps_pulse, cmd_ready, cmd_done, cmd_err;
    logic       locked, err_timeout, lock_lost;
    logic [2:0] ps_sel;

    logic       t_lock = 1'b0;
    logic       t_valid = 1'b0;
    logic [2:0] t_sel_in = '0;
    logic       t_dir_in = 1'b0;
    logic [7:0] t_steps_in = '0;
    logic       t_pll_reset, t_ps_dir, t_ps_pulse, t_ready, t_done, t_err;
    logic       t_locked, t_err_timeout, t_lock_lost;
    logic [2:0] t_ps_sel;

    int total = 0;
    int bad = 0;
    logic [2:0] exp_sel = '0;
    logic       exp_dir = 1'b0;
    int         tmo_rises;
    logic       tmo_prev;

    always #5 clk = ~clk;

    pll_phase_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .ps_sel(ps_sel), .ps_dir(ps_dir), .ps_pulse(ps_pulse),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_done(cmd_done),
        .cmd_err(cmd_err), .locked(locked), .err_timeout(err_timeout),
        .lock_lost(lock_lost)
    );

    pll_phase_ctrl #(.RST_CYCLES(4), .LOCK_TIMEOUT(32)) u_tmo (
        .clk(clk), .rst_n(rst_n), .pll_lock(t_lock), .pll_reset(t_pll_reset),
        .ps_sel(t_ps_sel), .ps_dir(t_ps_dir), .ps_pulse(t_ps_pulse),
        .cmd_valid(t_valid), .cmd_ready(t_ready), .cmd_sel(t_sel_in),
        .cmd_dir(t_dir_in), .cmd_steps(t_steps_in), .cmd_done(t_done),
        .cmd_err(t_err), .locked(t_locked), .err_timeout(t_err_timeout),
        .lock_lost(t_lock_lost)
    );

    // Count re-assertions of pll_reset on the never-locking instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_rises <= 0;
            tmo_prev  <= 1'b1;
        end else begin
            tmo_prev <= t_pll_reset;
            if (t_pll_reset && !tmo_prev) tmo_rises <= tmo_rises + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic model_pulse(input int j, input int n);
        int t;
        t = j - 2;
        return (j >= 2) && (t < n * (PW + GW)) && ((t % (PW + GW)) < PW);
    endfunction

    task automatic bring_up();
        int hi;
        int k;
        pll_lock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (pll_reset) hi++;
            @(negedge clk);
        end
        check("rst_cycles", hi, 16);
        pll_lock = 1'b1;
        k = 0;
        while (!locked && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("lock_latency", k, 3);
        check("no_timeout", err_timeout, 0);
    endtask

    task automatic run_cmd(input logic [2:0] sel, input logic dir, input logic [7:0] steps,
                           input int drop_at);
        int  n, lat, wait_n, olat, oerr, bad_pulse, bad_hold;
        logic exp_err;
        wait_n = 0;
        while (!cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_dir   = dir;
        cmd_steps = steps;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_sel   = 3'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_steps = 8'($urandom);
        n = (sel == 3'd7) ? 0 : int'(steps);
        if (sel != 3'd7) begin
            exp_sel = sel;
            exp_dir = dir;
        end
        lat     = (n == 0) ? 1 : 2 + n * (PW + GW);
        exp_err = (sel == 3'd7);
        if (RELOCK && drop_at > 0 && drop_at + 3 <= lat) begin
            lat     = drop_at + 3;
            exp_err = 1'b1;
        end
        olat = -1;
        oerr = 0;
        bad_pulse = 0;
        bad_hold  = 0;
        for (int j = 1; j <= lat + 20; j++) begin
            if (j == drop_at) pll_lock = 1'b0;
            if (ps_pulse !== ((j < lat) ? model_pulse(j, n) : 1'b0)) bad_pulse++;
            if (ps_sel !== exp_sel || ps_dir !== exp_dir) bad_hold++;
            if (cmd_done === 1'b1) begin
                olat = j;
                oerr = int'(cmd_err);
                break;
            end
            if (cmd_err !== 1'b0) bad_pulse++;
            @(negedge clk);
        end
        check("latency", olat, lat);
        check("cmd_err", oerr, int'(exp_err));
        check("pulse_shape", bad_pulse, 0);
        check("sel_dir_hold", bad_hold, 0);
        @(negedge clk);
        check("done_one_cycle", {cmd_done, cmd_err}, 0);
    endtask

    initial begin
        int k;
        int stray;
        repeat (2) @(negedge clk);
        check("reset_outs",
              {pll_reset, ps_sel, ps_dir, ps_pulse, cmd_ready, cmd_done, cmd_err,
               locked, err_timeout, lock_lost}, 32'b1_000_0_0_0_0_0_0_0_0);

        bring_up();
        check("tmo_err_timeout", t_err_timeout, 1);
        check("tmo_cycling", tmo_rises >= 2, 1);
        check("tmo_not_locked", t_locked, 0);

        run_cmd(3'd2, 1'b1, 8'd3, 0);
        run_cmd(3'd4, 1'b0, 8'd0, 0);
        run_cmd(3'd7, 1'b1, 8'd5, 0);
        run_cmd(3'd3, 1'b0, 8'd255, 0);
        run_cmd(3'd0, 1'b1, 8'd1, 0);
        run_cmd(3'd6, 1'b0, 8'd2, 0);
        for (int i = 0; i < 16; i++)
            run_cmd(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom_range(0, 10)), 0);

        // Lock drops during pulse 2 of 5
        run_cmd(3'd1, 1'b0, 8'd5, 11);
        check("lock_lost_set", lock_lost, 1);
        if (RELOCK) begin
            check("relock_locked_low", locked, 0);
            check("relock_reset_high", pll_reset, 1);
            pll_lock = 1'b1;
            k = 0;
            while (!locked && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("relocked", locked, 1);
        end else begin
            stray = 0;
            for (int i = 0; i < 5; i++) begin
                if (cmd_ready !== 1'b0 || locked !== 1'b1) stray++;
                @(negedge clk);
            end
            check("ready_low_while_unlocked", stray, 0);
            pll_lock = 1'b1;
            k = 0;
            while (!cmd_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("ready_after_relock", cmd_ready, 1);
        end
        run_cmd(3'd5, 1'b1, 8'd2, 0);

        // Reset asserted during a pulse
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b1;
        cmd_sel   = 3'd5;
        cmd_dir   = 1'b0;
        cmd_steps = 8'd4;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("phi_before_rst", ps_pulse, 1);
        rst_n = 1'b0;
        #1;
        check("rst_kills_pulse", {ps_pulse, pll_reset, locked}, 3'b010);
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cmd_done !== 1'b0) stray++;
        end
        check("no_done_on_reset", stray, 0);
        exp_sel = '0;
        exp_dir = 1'b0;
        check("ps_sel_cleared", {ps_sel, ps_dir}, 0);
        bring_up();
        run_cmd(3'd5, 1'b1, 8'd2, 0);
        check("final_no_timeout", err_timeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_phase_ctrl.md
PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_reset is held high per reset attempt; legal range 2..255.
REQ-002 Parameter LOCK_TIMEOUT, default 65535: cycles to wait for lock after pll_reset releases; legal range 16..65535.
REQ-003 Parameter PULSE_W, default 4: ps_pulse high width in cycles; legal range 1..15.
REQ-004 Parameter GAP_W, default 4: ps_pulse low gap after each pulse in cycles; legal range 1..15.
REQ-005 clk  in  1  controller clock, the only clock.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 pll_lock  in  1  PLL LOCK, asynchronous to clk.
REQ-008 pll_reset  out  1  PLL RESET, active high.
REQ-009 ps_sel  out  3  PLL PSSEL, output select 0..6.
REQ-010 ps_dir  out  1  PLL PSDIR.
REQ-011 ps_pulse  out  1  PLL PSPULSE.
REQ-012 cmd_valid  in  1  phase-shift request valid.
REQ-013 cmd_ready  out  1  controller can accept a request.
REQ-014 cmd_sel  in  3  target output, 0..6.
REQ-015 cmd_dir  in  1  shift direction.
REQ-016 cmd_steps  in  8  number of phase steps, 0..255.
REQ-017 cmd_done  out  1  one-cycle pulse at command completion.
REQ-018 cmd_err  out  1  qualifies cmd_done: command rejected or aborted.
REQ-019 locked  out  1  PLL locked and controller operational.
REQ-020 err_timeout  out  1  sticky: a lock attempt has timed out.
REQ-021 lock_lost  out  1  sticky: synchronized lock fell while in IDLE, SETUP, PHI or PLO.

Function
REQ-022 pll_lock SHALL pass through a 2-flop synchronizer; every use of lock below refers to the synchronized value.
REQ-023 FSM states SHALL be RST, WLOCK, IDLE, SETUP, PHI and PLO.
REQ-024 RST SHALL drive pll_reset=1 for RST_CYCLES cycles and then go to WLOCK.
REQ-025 WLOCK SHALL drive pll_reset=0; lock=1 goes to IDLE; LOCK_TIMEOUT cycles without lock SHALL set err_timeout and go to RST (retry forever).
REQ-026 locked SHALL be 1 only in IDLE, SETUP, PHI and PLO.
REQ-027 cmd_ready SHALL be 1 only in IDLE with lock=1; a handshake is cmd_valid and cmd_ready in the same cycle.
REQ-028 On handshake, cmd_sel, cmd_dir and cmd_steps SHALL be registered; ps_sel and ps_dir SHALL take the registered values and hold stable until the next handshake.
REQ-029 Handshake with cmd_sel=7 SHALL produce cmd_done=1 and cmd_err=1 on the next cycle, with no pulses; FSM stays in IDLE.
REQ-030 Handshake with cmd_steps=0 SHALL produce cmd_done=1 and cmd_err=0 on the next cycle, with no pulses.
REQ-031 Otherwise the FSM SHALL go to SETUP for 1 cycle with ps_pulse=0, then repeat N times: PHI (ps_pulse=1, PULSE_W cycles), then PLO (ps_pulse=0, GAP_W cycles).
REQ-032 cmd_done=1 (cmd_err=0) SHALL assert in the cycle after the last PLO cycle, coincident with the return to IDLE.
REQ-033 Command latency from handshake to cmd_done SHALL be 1 + N*(PULSE_W+GAP_W) + 1 cycles.
REQ-034 The step counter SHALL be 8 bits and count down with no wrap; 255 steps are fully supported.
REQ-035 cmd_done and cmd_err SHALL be 0 in every cycle except the done cycle.

Reset
REQ-036 rst_n=0 SHALL asynchronously force: state RST with counter cleared, pll_reset=1, ps_sel=0, ps_dir=0, ps_pulse=0, cmd_ready=0, cmd_done=0, cmd_err=0, locked=0, err_timeout=0, lock_lost=0, synchronizer flops=0.
REQ-037 Reset asserted mid-command SHALL abort the command with no cmd_done; release of rst_n SHALL begin a full RST sequence.

Configuration
REQ-038 Macro PLL_PHASE_CTRL_RELOCK_EN SHALL control the response to a lock drop.
REQ-039 With the macro defined: lock=0 in IDLE, SETUP, PHI or PLO SHALL set lock_lost; drive ps_pulse=0 the next cycle; pulse cmd_done=1 and cmd_err=1 if a command was active; and go to RST.
REQ-040 Without the macro: the same lock drop SHALL only set lock_lost; an active command SHALL complete normally; cmd_ready stays 0 while lock=0; the FSM never leaves IDLE, SETUP, PHI or PLO except on rst_n.

Verification
REQ-041 Bring-up: release rst_n, assert pll_lock 100 cycles later -> pll_reset high exactly 16 cycles; locked=1 3 cycles after pll_lock rises (2 synchronizer cycles plus the WLOCK-to-IDLE transition); err_timeout=0.
REQ-042 Command sel=2, dir=1, steps=3 with defaults -> ps_sel=2 and ps_dir=1 held; exactly 3 pulses each 4 cycles high with 4-cycle gaps; cmd_done/cmd_err=1/0 26 cycles after handshake.
REQ-043 Boundaries: steps=0 -> done with no pulse, 1 cycle after handshake; sel=7 -> done with cmd_err=1; steps=255 -> 255 pulses, latency 2042 cycles.
REQ-044 Timeout: LOCK_TIMEOUT=32, pll_lock held 0 -> err_timeout set, pll_reset re-asserts, and it keeps cycling.
REQ-045 Lock loss mid-command: drop pll_lock during pulse 2 of 5 -> with macro, abort with cmd_err=1, lock_lost=1 and relock; without macro, all 5 pulses issued, lock_lost=1 and cmd_ready stays 0.
REQ-046 Assert rst_n=0 during PHI -> ps_pulse=0 immediately, no cmd_done, and a full reset sequence on release.
